output_display: RTL and testbench

- Downstream consumer of the CPU's `output_port[15:0]` and `PC_below8bit[7:0]`.
- Registers the displayed word and shows it as 4 hex digits on a time-multiplexed 7-segment display.
- Mirrors the PC low byte on 8 LEDs.
- Flags value changes on the decimal point (DP) of the rightmost digit.
- Sits between the CPU and the board pins (takes the place of `output_logic.v`).

---
 rtl/output_display_pkg.sv | 14 +
 rtl/output_display_if.sv | 14 +
 rtl/output_display_hex_to_seg.sv | 9 +
 rtl/output_display.sv | 58 +++++
 tb/tb_output_display.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/output_display_pkg.sv
// output_display_pkg: shared word size, blank codes, hex segment table and blanking helper
package output_display_pkg;
  localparam int WORD_SIZE = 16;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF = 4'hF;
  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  function automatic logic blank_digit(logic [WORD_SIZE-1:0] word, logic [1:0] idx);
    return idx != 2'd0 && (word >> {idx, 2'b00}) == '0;
  endfunction
endpackage

// File: rtl/output_display_if.sv
// output_display_if: CPU-side inputs and board-side outputs of the display block
interface output_display_if;
  import output_display_pkg::*;
  logic [WORD_SIZE-1:0] data_in;
  logic [7:0] pc_in;
  logic display_enable;
  logic hold;
  logic [3:0] an;
  logic [6:0] seg;
  logic dp;
  logic [7:0] led;
  modport master (output data_in, pc_in, display_enable, hold, input an, seg, dp, led);
  modport slave (input data_in, pc_in, display_enable, hold, output an, seg, dp, led);
endinterface

// File: rtl/output_display_hex_to_seg.sv
// hex_to_seg: nibble to active-low 7-segment pattern
module hex_to_seg
  import output_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  assign seg = HEX_SEG[nibble];
endmodule

// File: rtl/output_display.sv
// output_display: latches the CPU output word, scans it as 4 hex digits and mirrors the PC low byte on LEDs
module output_display
  import output_display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int CHANGE_FRAMES = 64,
  parameter bit BLANK_LEADING = 1'b0
) (
  input logic clk,
  input logic reset_display,
  output_display_if.slave bus
);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int FW = $clog2(CHANGE_FRAMES + 1);
  logic [WORD_SIZE-1:0] latched;
  logic [RW-1:0] refresh_cnt;
  logic [1:0] digit_idx;
  logic [FW-1:0] frame_cnt;
  logic change_active;
  logic [3:0] nibble;
  logic [6:0] pattern;
  logic change, tick, wrap;
  assign nibble = latched[{digit_idx, 2'b00} +: 4];
  assign change = !bus.hold && bus.data_in != latched;
  assign tick = bus.display_enable && refresh_cnt == RW'(REFRESH_DIV - 1);
  assign wrap = tick && digit_idx == 2'd3;
  hex_to_seg u_dec (.nibble(nibble), .seg(pattern));
  always_ff @(posedge clk or posedge reset_display)
    if (reset_display) begin
      latched <= '0;
      refresh_cnt <= '0;
      digit_idx <= 2'd0;
      frame_cnt <= '0;
      change_active <= 1'b0;
      bus.an <= AN_OFF;
      bus.seg <= SEG_BLANK;
      bus.dp <= 1'b1;
      bus.led <= 8'h00;
    end else begin
      if (!bus.hold) latched <= bus.data_in;
      bus.led <= bus.pc_in;
      if (bus.display_enable) begin
        refresh_cnt <= tick ? '0 : refresh_cnt + 1'b1;
        if (tick) digit_idx <= digit_idx + 1'b1;
      end
      // A fresh change reloads the frame count even on the frame-wrap edge.
      if (change) begin
        change_active <= 1'b1;
        frame_cnt <= FW'(CHANGE_FRAMES);
      end else if (wrap && change_active) begin
        frame_cnt <= frame_cnt - 1'b1;
        if (frame_cnt == FW'(1)) change_active <= 1'b0;
      end
      bus.an <= bus.display_enable ? ~(4'b0001 << digit_idx) : AN_OFF;
      bus.seg <= !bus.display_enable || (BLANK_LEADING && blank_digit(latched, digit_idx)) ? SEG_BLANK : pattern;
      bus.dp <= !(bus.display_enable && digit_idx == 2'd0 && change_active);
    end
endmodule

// File: tb/tb_output_display.sv
// tb_output_display: directed stimulus with a scoreboard checking each newly lit digit of two display instances
module tb_output_display;
  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic dp;
  } disp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] data = 16'h0000;
  logic [7:0] pc = 8'h00;
  logic hold = 1'b0;
  logic en_a = 1'b0;
  logic en_b = 1'b0;
  int checks = 0;
  int failures = 0;
  disp_t qa[$];
  disp_t qb[$];
  logic [3:0] prev_a = 4'hF;
  logic [3:0] prev_b = 4'hF;
  output_display_if ifa ();
  output_display_if ifb ();
  assign ifa.data_in = data;
  assign ifa.pc_in = pc;
  assign ifa.hold = hold;
  assign ifa.display_enable = en_a;
  assign ifb.data_in = data;
  assign ifb.pc_in = pc;
  assign ifb.hold = hold;
  assign ifb.display_enable = en_b;
  output_display #(.REFRESH_DIV(4), .CHANGE_FRAMES(2), .BLANK_LEADING(1'b0)) dut_a (
    .clk(clk), .reset_display(rst), .bus(ifa.slave));
  output_display #(.REFRESH_DIV(4), .CHANGE_FRAMES(2), .BLANK_LEADING(1'b1)) dut_b (
    .clk(clk), .reset_display(rst), .bus(ifb.slave));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic push_frame_a(input logic [6:0] s0, s1, s2, s3, input logic dp0);
    qa.push_back({4'b1110, s0, dp0});
    qa.push_back({4'b1101, s1, 1'b1});
    qa.push_back({4'b1011, s2, 1'b1});
    qa.push_back({4'b0111, s3, 1'b1});
  endtask
  task automatic push_frame_b(input logic [6:0] s0, s1, s2, s3, input logic dp0);
    qb.push_back({4'b1110, s0, dp0});
    qb.push_back({4'b1101, s1, 1'b1});
    qb.push_back({4'b1011, s2, 1'b1});
    qb.push_back({4'b0111, s3, 1'b1});
  endtask
  // A digit is "presented" when a new anode pattern other than all-off appears.
  always @(negedge clk) begin
    disp_t got, exp;
    got = {ifa.an, ifa.seg, ifa.dp};
    if (ifa.an !== prev_a && ifa.an !== 4'hF) begin
      checks++;
      if (qa.size() == 0) begin
        failures++;
        $display("FAIL dut_a unexpected digit: got an=%b seg=%h dp=%b", got.an, got.seg, got.dp);
      end else begin
        exp = qa.pop_front();
        if (got !== exp) begin
          failures++;
          $display("FAIL dut_a digit: got an=%b seg=%h dp=%b expected an=%b seg=%h dp=%b",
                   got.an, got.seg, got.dp, exp.an, exp.seg, exp.dp);
        end
      end
    end
    prev_a = ifa.an;
  end
  always @(negedge clk) begin
    disp_t got, exp;
    got = {ifb.an, ifb.seg, ifb.dp};
    if (ifb.an !== prev_b && ifb.an !== 4'hF) begin
      checks++;
      if (qb.size() == 0) begin
        failures++;
        $display("FAIL dut_b unexpected digit: got an=%b seg=%h dp=%b", got.an, got.seg, got.dp);
      end else begin
        exp = qb.pop_front();
        if (got !== exp) begin
          failures++;
          $display("FAIL dut_b digit: got an=%b seg=%h dp=%b expected an=%b seg=%h dp=%b",
                   got.an, got.seg, got.dp, exp.an, exp.seg, exp.dp);
        end
      end
    end
    prev_b = ifb.an;
  end
  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (2) @(negedge clk);
    check("reset_an", 16'(ifa.an), 16'hF);
    check("reset_seg", 16'(ifa.seg), 16'h7F);
    check("reset_dp", 16'(ifa.dp), 16'h1);
    check("reset_led", 16'(ifa.led), 16'h00);
    data = 16'h12AF;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    push_frame_a(7'h0E, 7'h08, 7'h24, 7'h79, 1'b0);
    push_frame_a(7'h0E, 7'h08, 7'h24, 7'h79, 1'b0);
    push_frame_a(7'h0E, 7'h08, 7'h24, 7'h79, 1'b1);
    push_frame_a(7'h0E, 7'h08, 7'h24, 7'h79, 1'b1);
    push_frame_a(7'h0E, 7'h08, 7'h24, 7'h79, 1'b1);
    push_frame_a(7'h0E, 7'h0E, 7'h0E, 7'h0E, 1'b0);
    push_frame_a(7'h0E, 7'h0E, 7'h0E, 7'h0E, 1'b0);
    push_frame_a(7'h0E, 7'h0E, 7'h0E, 7'h0E, 1'b1);
    qa.push_back({4'b1110, 7'h0E, 1'b1});
    qa.push_back({4'b1101, 7'h0E, 1'b1});
    qa.push_back({4'b1011, 7'h0E, 1'b1});
    en_a = 1'b1;
    pc = 8'h5A;
    @(negedge clk);
    check("led_enabled", 16'(ifa.led), 16'h5A);
    repeat (45) @(negedge clk);
    hold = 1'b1;
    data = 16'hFFFF;
    repeat (33) @(negedge clk);
    hold = 1'b0;
    repeat (59) @(negedge clk);
    en_a = 1'b0;
    pc = 8'h2C;
    @(negedge clk);
    check("disable_an", 16'(ifa.an), 16'hF);
    check("disable_seg", 16'(ifa.seg), 16'h7F);
    check("disable_dp", 16'(ifa.dp), 16'h1);
    check("led_disabled", 16'(ifa.led), 16'h2C);
    repeat (19) @(negedge clk);
    qa.push_back({4'b1011, 7'h0E, 1'b1});
    qa.push_back({4'b0111, 7'h0E, 1'b1});
    qa.push_back({4'b1110, 7'h0E, 1'b1});
    qa.push_back({4'b1101, 7'h0E, 1'b1});
    en_a = 1'b1;
    @(negedge clk);
    check("resume_first_an", 16'(ifa.an), 16'hB);
    @(negedge clk);
    check("resume_second_an", 16'(ifa.an), 16'hB);
    @(negedge clk);
    check("resume_next_an", 16'(ifa.an), 16'h7);
    repeat (8) @(negedge clk);
    qa.push_back({4'b1110, 7'h40, 1'b1});
    #2 rst = 1'b1;
    #1;
    check("async_reset_an", 16'(ifa.an), 16'hF);
    check("async_reset_seg", 16'(ifa.seg), 16'h7F);
    check("async_reset_dp", 16'(ifa.dp), 16'h1);
    check("async_reset_led", 16'(ifa.led), 16'h00);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    en_a = 1'b0;
    data = 16'h0030;
    @(negedge clk);
    push_frame_b(7'h40, 7'h30, 7'h7F, 7'h7F, 1'b0);
    push_frame_b(7'h40, 7'h30, 7'h7F, 7'h7F, 1'b0);
    push_frame_b(7'h40, 7'h30, 7'h7F, 7'h7F, 1'b1);
    en_b = 1'b1;
    repeat (47) @(negedge clk);
    en_b = 1'b0;
    for (int i = 0; i < 100 && (qa.size() != 0 || qb.size() != 0); i++) @(negedge clk);
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d/%0d digits outstanding expected 0/0", qa.size(), qb.size());
    end
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
